// File: rtl/pulse_stretch.sv
// Per-channel pulse-to-level stretcher: each din request holds dout active for
// HOLD_CYCLES cycles, optionally reloading on pulses that arrive during the hold.
module pulse_stretch #(
    parameter int unsigned DATA_WIDTH   = 1,
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter bit          RETRIGGER    = 1'b1,
    parameter bit          OUT_POLARITY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  busy
);

    localparam int unsigned     CW       = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0]   HOLD_VAL = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0]   ONE      = CW'(1);
    localparam logic            ACT      = OUT_POLARITY;
    localparam logic            INACT    = ~OUT_POLARITY;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t          state [DATA_WIDTH];
    logic [CW-1:0]   cnt   [DATA_WIDTH];

    // dout is registered alongside the state so it always equals the mapped state.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (rst) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
                dout[i]  <= INACT;
            end else begin
                case (state[i])
                    IDLE: begin
                        if (din[i]) begin
                            state[i] <= HOLD;
                            cnt[i]   <= HOLD_VAL;
                            dout[i]  <= ACT;
                        end
                    end
                    HOLD: begin
                        if (RETRIGGER && din[i]) begin
                            cnt[i] <= HOLD_VAL;
                        end else if (cnt[i] == ONE) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                            dout[i]  <= INACT;
                        end else begin
                            cnt[i] <= cnt[i] - ONE;
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                        dout[i]  <= INACT;
                    end
                endcase
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            busy = busy | (state[i] == HOLD);
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Randomized bench for pulse_stretch across four parameter sets, checked against
// an edge-index model: output is active while the governing trigger edge is recent.
module tb_pulse_stretch;

    localparam int H_A = 4;
    localparam int H_B = 3;
    localparam int H_C = 1;
    localparam int H_D = 1;
    localparam int NEVER = -1000000;
    localparam int N_CYCLES = 800;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;

    logic [3:0] dout_a, dout_b;
    logic [1:0] dout_c;
    logic [0:0] dout_d;
    logic       busy_a, busy_b, busy_c, busy_d;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pulse_stretch #(.DATA_WIDTH(4), .HOLD_CYCLES(H_A), .RETRIGGER(1'b1), .OUT_POLARITY(1'b1)) u_a (
        .clk(clk), .rst(rst), .din(din), .dout(dout_a), .busy(busy_a));
    pulse_stretch #(.DATA_WIDTH(4), .HOLD_CYCLES(H_B), .RETRIGGER(1'b0), .OUT_POLARITY(1'b0)) u_b (
        .clk(clk), .rst(rst), .din(din), .dout(dout_b), .busy(busy_b));
    pulse_stretch #(.DATA_WIDTH(2), .HOLD_CYCLES(H_C), .RETRIGGER(1'b0), .OUT_POLARITY(1'b1)) u_c (
        .clk(clk), .rst(rst), .din(din[1:0]), .dout(dout_c), .busy(busy_c));
    pulse_stretch #(.DATA_WIDTH(1), .HOLD_CYCLES(H_D), .RETRIGGER(1'b1), .OUT_POLARITY(1'b1)) u_d (
        .clk(clk), .rst(rst), .din(din[0:0]), .dout(dout_d), .busy(busy_d));

    // Retrigger sets: edge index of the latest high sample since reset.
    // Non-retrigger sets: edge index of the latest accepted trigger since reset.
    int hi_a  [4];
    int acc_b [4];
    int acc_c [2];
    int hi_d  [1];
    int edge_n = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit recent(input int last, input int e, input int h);
        return last > e - h;
    endfunction

    // Apply the inputs that will be sampled at the next rising edge.
    task automatic model_edge();
        edge_n++;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                hi_a[i]  = NEVER;
                acc_b[i] = NEVER;
            end else begin
                if (din[i]) hi_a[i] = edge_n;
                if (din[i] && !recent(acc_b[i], edge_n - 1, H_B)) acc_b[i] = edge_n;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (rst) acc_c[i] = NEVER;
            else if (din[i] && !recent(acc_c[i], edge_n - 1, H_C)) acc_c[i] = edge_n;
        end
        if (rst) hi_d[0] = NEVER;
        else if (din[0]) hi_d[0] = edge_n;
    endtask

    task automatic check_all(input int cyc);
        logic [3:0] ea, eb;
        logic [1:0] ec;
        logic [0:0] ed;
        for (int i = 0; i < 4; i++) begin
            ea[i] = recent(hi_a[i], edge_n, H_A);
            eb[i] = ~recent(acc_b[i], edge_n, H_B);
        end
        for (int i = 0; i < 2; i++) ec[i] = recent(acc_c[i], edge_n, H_C);
        ed[0] = recent(hi_d[0], edge_n, H_D);
        check($sformatf("dout_a@%0d", cyc), 32'(dout_a), 32'(ea));
        check($sformatf("busy_a@%0d", cyc), 32'(busy_a), 32'(|ea));
        check($sformatf("dout_b@%0d", cyc), 32'(dout_b), 32'(eb));
        check($sformatf("busy_b@%0d", cyc), 32'(busy_b), 32'(~&eb));
        check($sformatf("dout_c@%0d", cyc), 32'(dout_c), 32'(ec));
        check($sformatf("busy_c@%0d", cyc), 32'(busy_c), 32'(|ec));
        check($sformatf("dout_d@%0d", cyc), 32'(dout_d), 32'(ed));
        check($sformatf("busy_d@%0d", cyc), 32'(busy_d), 32'(ed[0]));
    endtask

    initial begin
        int mode;
        rst = 1'b1;
        din = '1;
        model_edge();
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            check_all(cyc);
            if (cyc % 24 == 0) mode = $urandom_range(0, 3);
            if (cyc < 1) begin
                rst = 1'b1;
                din = '1;
            end else begin
                rst = ($urandom_range(0, 59) == 0);
                for (int i = 0; i < 4; i++) begin
                    case (mode)
                        0: din[i] = ($urandom_range(0, 7) == 0);
                        1: din[i] = 1'($urandom_range(0, 1));
                        2: din[i] = 1'b1;
                        default: din[i] = 1'b0;
                    endcase
                end
            end
            model_edge();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pulse_stretch.md
# pulse_stretch

Per-channel pulse-to-level converter. Each single-cycle (or longer) request pulse on `din` is stretched into a registered level on `dout` held for a programmable number of cycles. It drives slow consumers from pulse sources such as edge detectors and bus strobes. Typical consumers are LEDs, external enables and cross-domain-safe flags.

## Interface

Parameters:
- `DATA_WIDTH`, default 1: number of independent channels.
- `HOLD_CYCLES`, default 4: cycles `dout` stays active per trigger. Legal range 1..65535.
- `RETRIGGER`, default 1: 1 means a pulse during hold reloads the counter; 0 means pulses during hold are ignored.
- `OUT_POLARITY`, default 1: 1 means active-high `dout`; 0 means active-low `dout`. Input is always active-high.

Ports:
- `clk`, input, 1: the single clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `din`, input, DATA_WIDTH: request pulses, one bit per channel, sampled each rising edge.
- `dout`, output, DATA_WIDTH: stretched level per channel. Registered.
- `busy`, output, 1: OR of all channels in HOLD. Registered-equivalent, derived from state flops only.

## Operation

- Each channel runs an independent 2-state FSM, IDLE / HOLD.
- Each channel has a down-counter `cnt` of width `$clog2(HOLD_CYCLES+1)`, unsigned. The counter never underflows.
- **IDLE**, `cnt = 0`:
  - `din[i] = 1` → go to HOLD, `cnt ← HOLD_CYCLES`.
  - Otherwise stay in IDLE.
- **HOLD**, `cnt ≥ 1`:
  - With `RETRIGGER = 1` and `din[i] = 1`: `cnt ← HOLD_CYCLES` and stay in HOLD.
  - With `RETRIGGER = 0`, or `din[i] = 0`:
    - `cnt = 1` → go to IDLE, `cnt ← 0`.
    - Otherwise `cnt ← cnt − 1`.
  - With `RETRIGGER = 0`, `din[i]` is ignored for the whole HOLD period, including the final HOLD cycle.
- Output mapping:
  - `dout[i]` is active exactly when channel i is in HOLD.
  - Active level is 1 if `OUT_POLARITY = 1`, else 0.
- `busy = |(state == HOLD)` across channels.
- **Reset** (`rst = 1` at a rising edge):
  - All channels go to IDLE with `cnt = 0`.
  - `dout` goes to the inactive level: all 0 when `OUT_POLARITY = 1`, all 1 when `OUT_POLARITY = 0`.
  - `busy` goes to 0.
  - Reset overrides `din` in the same cycle.
  - Reset during HOLD aborts the stretch immediately. No residual output.
- Channels never interact. Simultaneous triggers on several channels are handled independently.

## Timing

- **Latency:** `din[i]` high at rising edge n → `dout[i]` active from after edge n, i.e. visible in cycle n+1.
- **Non-retriggered stretch:** `dout[i]` is active for exactly HOLD_CYCLES consecutive cycles, n+1 .. n+HOLD_CYCLES.
- **Pulse width independence:**
  - With `RETRIGGER = 0`, output width is HOLD_CYCLES for any `din` pulse length ≤ HOLD_CYCLES.
  - A `din` held continuously high yields a repeating pattern of HOLD_CYCLES active cycles then 1 inactive cycle. The IDLE cycle is mandatory.
- **Continuous retrigger:** with `RETRIGGER = 1` and `din` high continuously, `dout` stays active until HOLD_CYCLES cycles after the last high sample.
- **HOLD_CYCLES = 1:**
  - `dout` is a 1-cycle-delayed copy of `din` when `RETRIGGER = 1`.
  - With `RETRIGGER = 0`, alternate cycles only for constant-high `din`.
- **Counter width:** `$clog2(HOLD_CYCLES+1)` bits. HOLD_CYCLES must be representable; no wrap is ever permitted.
- There are no combinational paths from `din` to `dout` or `busy`.

## Test plan

- **Reset values:** with `OUT_POLARITY = 1`, assert `rst` for 2 cycles while `din = 1` → `dout = 0`, `busy = 0` during reset. After release, `dout` goes high the cycle after the first sampled `din = 1`. With `OUT_POLARITY = 0`, `dout` is all ones during reset.
- **Single pulse:** `HOLD_CYCLES = 4`, 1-cycle `din` pulse at edge 10 → `dout` high in cycles 11–14 and low in cycle 15. `busy` tracks `dout`.
- **Retrigger:** `RETRIGGER = 1`, `HOLD_CYCLES = 4`, pulses at edges 10 and 12 → `dout` high in cycles 11–16 (6 cycles). With `RETRIGGER = 0`, the same stimulus gives cycles 11–14 only.
- **Constant high, no retrigger:** `RETRIGGER = 0`, `HOLD_CYCLES = 3`, `din = 1` forever → `dout` pattern 1,1,1,0 repeating. With `RETRIGGER = 1` the same stimulus gives a constant 1.
- **Reset mid-hold:** `HOLD_CYCLES = 8`, pulse at edge 10, `rst` at edge 13 → `dout` inactive from cycle 14 onward. A new pulse at edge 15 gives a full 8-cycle stretch, cycles 16–23.
- **Multi-channel independence:** `DATA_WIDTH = 4`. Pulse ch0 at edge 10, ch3 at edge 12, ch0 and ch1 together at edge 20 → each channel follows its own window with no cross-effects. `busy` is the OR of the channel windows.
